// File: rtl/multicore_system_core_1_nios2_cpu_div_cell_if.sv
// Divider cell handshake bundle: E-stage operands/strobes in, M-stage results out.
interface multicore_system_core_1_nios2_cpu_div_cell_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             E_div_signed;
  logic             E_div_start;
  logic             E_div_kill;
  logic             M_div_busy;
  logic             M_div_done;
  logic [WIDTH-1:0] M_div_quot;
  logic [WIDTH-1:0] M_div_rem;

  modport master (
    output E_src1, E_src2, E_div_signed, E_div_start, E_div_kill,
    input  M_div_busy, M_div_done, M_div_quot, M_div_rem
  );

  modport slave (
    input  E_src1, E_src2, E_div_signed, E_div_start, E_div_kill,
    output M_div_busy, M_div_done, M_div_quot, M_div_rem
  );
endinterface

// File: rtl/multicore_system_core_1_nios2_cpu_div_cell.sv
// Iterative radix-2 restoring divider, signed/unsigned, fixed WIDTH+2 cycle latency.
//   state  | meaning
//   IDLE   | waiting for start; done pulse may be high here
//   CALC   | one quotient bit per cycle, MSB first
//   FIX    | sign correction and result write-back
module multicore_system_core_1_nios2_cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  multicore_system_core_1_nios2_cpu_div_cell_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] raw_dvd;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             done_q;

  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic             accept;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             load_out;

  assign src1_neg = bus.E_div_signed & bus.E_src1[WIDTH-1];
  assign src2_neg = bus.E_div_signed & bus.E_src2[WIDTH-1];
  assign abs1     = src1_neg ? (~bus.E_src1 + 1'b1) : bus.E_src1;
  assign abs2     = src2_neg ? (~bus.E_src2 + 1'b1) : bus.E_src2;

  // Partial remainder stays below the divisor, so rem[WIDTH] is zero and the
  // borrow out of this subtraction is the restore decision.
  assign trial   = {rem, dvd[WIDTH-1]} - {2'b00, dsr};
  assign q_bit   = ~trial[WIDTH+1];
  assign rem_nxt = q_bit ? trial[WIDTH:0] : {rem[WIDTH-1:0], dvd[WIDTH-1]};

  // Zero divisor bypasses sign handling and returns the raw dividend.
  assign quot_fix = div_zero ? {WIDTH{1'b1}} : (q_neg ? (~dvd + 1'b1) : dvd);
  assign rem_fix  = div_zero ? raw_dvd
                  : (r_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0]);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.E_div_start && !bus.E_div_kill) begin
          accept    = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.E_div_kill)
          state_nxt = S_IDLE;
        else if (count == '0)
          state_nxt = S_FIX;
      end
      S_FIX: begin
        state_nxt = S_IDLE;
        load_out  = !bus.E_div_kill;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      raw_dvd  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= load_out;
      if (accept) begin
        dvd      <= abs1;
        dsr      <= abs2;
        raw_dvd  <= bus.E_src1;
        q_neg    <= src1_neg ^ src2_neg;
        r_neg    <= src1_neg;
        div_zero <= (bus.E_src2 == '0);
        rem      <= '0;
        count    <= CW'(WIDTH - 1);
      end else if (state == S_CALC) begin
        rem <= rem_nxt;
        dvd <= {dvd[WIDTH-2:0], q_bit};
        if (count != '0)
          count <= count - 1'b1;
      end
      if (load_out) begin
        quot_q <= quot_fix;
        rem_q  <= rem_fix;
      end
    end
  end

  assign bus.M_div_busy = (state != S_IDLE);
  assign bus.M_div_done = done_q;
  assign bus.M_div_quot = quot_q;
  assign bus.M_div_rem  = rem_q;
endmodule

// File: tb/tb_multicore_system_core_1_nios2_cpu_div_cell.sv
// Directed bench for the divider cell: latency, sign cases, zero divisor, overlap, kill and reset.
module tb_multicore_system_core_1_nios2_cpu_div_cell;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  multicore_system_core_1_nios2_cpu_div_cell_if #(.WIDTH(WIDTH)) bus();

  multicore_system_core_1_nios2_cpu_div_cell #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.E_src1       = '0;
    bus.E_src2       = '0;
    bus.E_div_signed = 1'b0;
    bus.E_div_start  = 1'b0;
    bus.E_div_kill   = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [31:0] exp_q, input logic [31:0] exp_r, input string nm);
    bit bad_window;
    bus.E_src1       = a;
    bus.E_src2       = b;
    bus.E_div_signed = sg;
    bus.E_div_start  = 1'b1;
    step();
    bus.E_div_start  = 1'b0;
    bus.E_src1       = ~a;
    bus.E_src2       = a;
    bus.E_div_signed = ~sg;
    bad_window = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      if (bus.M_div_busy !== 1'b1 || bus.M_div_done !== 1'b0) bad_window = 1'b1;
      step();
    end
    checks++;
    if (bad_window) begin
      errors++;
      $display("FAIL %s busy_window: busy/done wrong within cycles 1..33", nm);
    end
    checks++;
    if (bus.M_div_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done@34: got %b want 1", nm, bus.M_div_done);
    end
    checks++;
    if (bus.M_div_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy@34: got %b want 0", nm, bus.M_div_busy);
    end
    checks++;
    if (bus.M_div_quot !== exp_q) begin
      errors++;
      $display("FAIL %s quot: got %h want %h", nm, bus.M_div_quot, exp_q);
    end
    checks++;
    if (bus.M_div_rem !== exp_r) begin
      errors++;
      $display("FAIL %s rem: got %h want %h", nm, bus.M_div_rem, exp_r);
    end
    step();
    checks++;
    if (bus.M_div_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done@35: got %b want 0", nm, bus.M_div_done);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    checks++;
    if (bus.M_div_busy !== 1'b0 || bus.M_div_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.M_div_busy, bus.M_div_done);
    end
    checks++;
    if (bus.M_div_quot !== 32'h0 || bus.M_div_rem !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: quot=%h rem=%h want 0 0", bus.M_div_quot, bus.M_div_rem);
    end
  endtask

  task automatic test_directed();
    run_op(32'd100,        32'd7,        1'b0, 32'd14,       32'd2,        "u_100_7");
    run_op(32'hFFFFFFF9,   32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, "s_m7_2");
    run_op(32'd7,          32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        "s_7_m2");
    run_op(32'hFFFFFFF9,   32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        "u_fff9_2");
    run_op(32'hFFFFFF9C,   32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, "s_m100_7");
    run_op(32'h80000000,   32'd3,        1'b0, 32'h2AAAAAAA, 32'd2,        "u_min_3");
    run_op(32'h80000000,   32'd2,        1'b1, 32'hC0000000, 32'd0,        "s_min_2");
    run_op(32'hFFFFFFFF,   32'hFFFFFFFF, 1'b1, 32'd1,        32'd0,        "s_m1_m1");
    run_op(32'hFFFFFFFF,   32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        "u_max_1");
    run_op(32'h7FFFFFFF,   32'h80000000, 1'b1, 32'd0,        32'h7FFFFFFF, "s_max_min");
    run_op(32'd0,          32'd5,        1'b0, 32'd0,        32'd0,        "u_0_5");
  endtask

  task automatic test_boundary();
    run_op(32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     "u_div0");
    run_op(32'h1234,     32'd0,        1'b1, 32'hFFFFFFFF, 32'h1234,     "s_div0");
    run_op(32'h80000000, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h80000000, "s_min_div0");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        "s_min_m1");
  endtask

  task automatic test_back_to_back();
    int dones;
    bit ok34, ok68, ok35;
    dones = 0;
    ok34 = 1'b0; ok68 = 1'b0; ok35 = 1'b0;
    for (int c = 0; c <= 72; c++) begin
      if (bus.M_div_done === 1'b1) dones++;
      if (c == 34) ok34 = (bus.M_div_done === 1'b1) && (bus.M_div_quot === 32'd10) && (bus.M_div_rem === 32'd0);
      if (c == 35) ok35 = (bus.M_div_busy === 1'b1);
      if (c == 68) ok68 = (bus.M_div_done === 1'b1) && (bus.M_div_quot === 32'd3) && (bus.M_div_rem === 32'd0);
      bus.E_div_start  = (c == 0) || (c == 5) || (c == 34);
      bus.E_div_signed = 1'b0;
      bus.E_src1       = (c == 0) ? 32'd50 : 32'd9;
      bus.E_src2       = (c == 0) ? 32'd5  : 32'd3;
      step();
    end
    idle_inputs();
    checks++;
    if (!ok34) begin
      errors++;
      $display("FAIL b2b_first: done=%b quot=%h want done at 34 q=a r=0", ok34, bus.M_div_quot);
    end
    checks++;
    if (!ok35) begin
      errors++;
      $display("FAIL b2b_accept_in_done: busy@35 got 0 want 1");
    end
    checks++;
    if (!ok68) begin
      errors++;
      $display("FAIL b2b_second: got quot=%h rem=%h want done at 68 q=3 r=0", bus.M_div_quot, bus.M_div_rem);
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 2", dones);
    end
  endtask

  task automatic test_kill();
    logic [31:0] prev_q, prev_r;
    bit saw_done, busy11;
    prev_q = bus.M_div_quot;
    prev_r = bus.M_div_rem;
    saw_done = 1'b0;
    busy11 = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      if (bus.M_div_done === 1'b1) saw_done = 1'b1;
      if (c == 11) busy11 = bus.M_div_busy;
      bus.E_div_start  = (c == 0);
      bus.E_div_kill   = (c == 10);
      bus.E_src1       = 32'd100;
      bus.E_src2       = 32'd7;
      step();
    end
    idle_inputs();
    checks++;
    if (busy11 !== 1'b0) begin
      errors++;
      $display("FAIL kill_busy@11: got %b want 0", busy11);
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL kill_no_done: got a done pulse want none");
    end
    checks++;
    if (bus.M_div_quot !== prev_q || bus.M_div_rem !== prev_r) begin
      errors++;
      $display("FAIL kill_outputs: got %h/%h want %h/%h", bus.M_div_quot, bus.M_div_rem, prev_q, prev_r);
    end
    bus.E_src1      = 32'd8;
    bus.E_src2      = 32'd2;
    bus.E_div_start = 1'b1;
    bus.E_div_kill  = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (bus.M_div_busy !== 1'b0) begin
      errors++;
      $display("FAIL kill_start_idle: busy got %b want 0", bus.M_div_busy);
    end
    bus.E_div_kill = 1'b1;
    step();
    idle_inputs();
    run_op(32'd21, 32'd4, 1'b0, 32'd5, 32'd1, "after_kill");
  endtask

  task automatic test_mid_reset();
    bit saw_done, ok11;
    saw_done = 1'b0;
    ok11 = 1'b0;
    for (int c = 0; c <= 45; c++) begin
      if (bus.M_div_done === 1'b1) saw_done = 1'b1;
      if (c == 11) ok11 = (bus.M_div_busy === 1'b0) && (bus.M_div_quot === 32'd0) && (bus.M_div_rem === 32'd0);
      bus.E_div_start = (c == 0);
      bus.E_src1      = 32'd100;
      bus.E_src2      = 32'd7;
      reset           = (c == 10);
      step();
    end
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (!ok11) begin
      errors++;
      $display("FAIL mid_reset_state@11: busy/quot/rem not cleared");
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_reset_no_done: got a done pulse want none");
    end
    run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "after_reset");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_directed();
    test_boundary();
    test_back_to_back();
    test_kill();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
